// File: rtl/qif_spike_isi_monitor_if.sv
// ISI readout channel between the spike monitor (master) and its consumer (slave).
// Handshake: an entry transfers on every clock edge where isi_valid && isi_ready; isi_data
// holds steady while isi_valid=1 and isi_ready=0; isi_ready may be driven regardless of isi_valid.
interface qif_spike_isi_monitor_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] isi_data;
  logic             isi_valid;
  logic             isi_ready;

  modport master (output isi_data, output isi_valid, input isi_ready);
  modport slave  (input isi_data, input isi_valid, output isi_ready);
endinterface

// File: rtl/qif_spike_isi_monitor.sv
// Spike-event monitor for the QIF neuron: measures inter-spike intervals into a small FIFO
// and reports a windowed spike-rate count.
module qif_spike_isi_monitor #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int WIN_LEN    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          spike_in,
  qif_spike_isi_monitor_if.master       isi_if,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [7:0]                    rate,
  output logic                          rate_valid,
  output logic                          dbg_state
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WCNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WIN_LEN - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t            state_q;
  logic              spike_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [7:0]        scnt_q, scnt_d;
  logic [7:0]        rate_q;
  logic              rate_valid_q;

  logic spike_evt, push, pop, push_ok, full;

  assign full = (count_q == COUNT_FULL);

  always_comb begin
    spike_evt = spike_in & ~spike_q & en;
    push      = spike_evt & (state_q == S_ARMED);
    pop       = (count_q != '0) & isi_if.isi_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok   = push & (~full | pop);
    count_d   = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    scnt_d = (scnt_q == 8'hFF) ? 8'hFF : scnt_q + {7'd0, spike_evt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (spike_evt) begin
      state_q <= S_ARMED;
      cnt_q   <= CNT_W'(1);
    end else if (en && state_q == S_ARMED && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= cnt_q;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q       <= '0;
      scnt_q       <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (en) begin
        if (wcnt_q == WIN_LAST) begin
          rate_q       <= scnt_d;
          rate_valid_q <= 1'b1;
          wcnt_q       <= '0;
          scnt_q       <= '0;
        end else begin
          wcnt_q <= wcnt_q + WCNT_W'(1);
          scnt_q <= scnt_d;
        end
      end
    end
  end

  assign isi_if.isi_valid = (count_q != '0);
  assign isi_if.isi_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign fifo_full        = full;
  assign overflow         = overflow_q;
  assign rate             = rate_q;
  assign rate_valid       = rate_valid_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_qif_spike_isi_monitor.sv
// Bench for qif_spike_isi_monitor: a reference model feeds an expected-ISI queue that is
// checked against the DUT readout, plus directed checks on timing, overflow, rate and reset.
module tb_qif_spike_isi_monitor;

  localparam int DEPTH = 4;
  localparam int WIN   = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic spike_in = 1'b0;
  logic fifo_full, overflow, rate_valid, dbg_state;
  logic [7:0] rate;
  logic fifo_full8, overflow8, rate_valid8, dbg_state8;
  logic [7:0] rate8;

  qif_spike_isi_monitor_if #(.CNT_W(16)) isi_if ();
  qif_spike_isi_monitor_if #(.CNT_W(8))  isi8_if ();

  qif_spike_isi_monitor #(.CNT_W(16), .FIFO_DEPTH(DEPTH), .WIN_LEN(WIN)) dut (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .isi_if(isi_if),
    .fifo_full(fifo_full), .overflow(overflow), .rate(rate), .rate_valid(rate_valid),
    .dbg_state(dbg_state)
  );

  qif_spike_isi_monitor #(.CNT_W(8), .FIFO_DEPTH(DEPTH), .WIN_LEN(WIN)) dut8 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .isi_if(isi8_if),
    .fifo_full(fifo_full8), .overflow(overflow8), .rate(rate8), .rate_valid(rate_valid8),
    .dbg_state(dbg_state8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic [7:0]  exp8_q[$];
  bit  m_spike_q, m_armed, m_overflow, m_rv;
  int  m_cnt, m_wcnt, m_scnt, m_rate;
  int  gcyc;

  // Observations
  logic [15:0] got_q[$];
  logic [7:0]  got8_q[$];
  int pulses[$];
  int rates[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, gcyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); exp8_q.delete();
    m_spike_q = 0; m_armed = 0; m_overflow = 0; m_rv = 0;
    m_cnt = 0; m_wcnt = 0; m_scnt = 0; m_rate = 0; gcyc = 0;
  endtask

  task automatic clear_obs();
    got_q.delete(); got8_q.delete(); pulses.delete(); rates.delete();
  endtask

  // Asynchronous reset asserted away from any clock edge; outputs must clear immediately.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    chk_eq("rst_isi_valid", isi_if.isi_valid, 0);
    chk_eq("rst_isi_data", isi_if.isi_data, 0);
    chk_eq("rst_fifo_full", fifo_full, 0);
    chk_eq("rst_overflow", overflow, 0);
    chk_eq("rst_rate", rate, 0);
    chk_eq("rst_rate_valid", rate_valid, 0);
    chk_eq("rst_state", dbg_state, 0);
    spike_in = 1'b0; en = 1'b0;
    isi_if.isi_ready = 1'b0; isi8_if.isi_ready = 1'b0;
    model_reset();
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, advance the model.
  task automatic step(input logic sp, input logic rdy, input logic e);
    bit ev, pop, push;
    int isi;
    spike_in = sp; en = e;
    isi_if.isi_ready = rdy; isi8_if.isi_ready = rdy;
    #1;
    chk_eq("isi_valid", isi_if.isi_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk_eq("isi_data", isi_if.isi_data, exp_q[0]);
      chk_eq("isi_data_w8", isi8_if.isi_data, exp8_q[0]);
    end
    if (isi_if.isi_valid && rdy) begin
      got_q.push_back(isi_if.isi_data);
      got8_q.push_back(isi8_if.isi_data);
    end
    chk_eq("fifo_full", fifo_full, exp_q.size() == DEPTH);
    chk_eq("overflow", overflow, m_overflow);
    chk_eq("rate", rate, m_rate);
    chk_eq("rate_valid", rate_valid, m_rv);
    if (rate_valid) begin
      pulses.push_back(gcyc);
      rates.push_back(rate);
    end

    ev   = sp && !m_spike_q && e;
    pop  = (exp_q.size() != 0) && rdy;
    push = ev && m_armed;
    isi  = m_cnt;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(exp8_q.pop_front());
    end
    if (push) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(16'(isi > 65535 ? 65535 : isi));
        exp8_q.push_back(8'(isi > 255 ? 255 : isi));
      end else begin
        m_overflow = 1;
      end
    end
    if (ev) begin
      m_armed = 1; m_cnt = 1;
    end else if (e && m_armed) begin
      m_cnt = m_cnt + 1;
    end
    m_rv = 0;
    if (e) begin
      if (m_wcnt == WIN - 1) begin
        m_rate = (m_scnt + ev > 255) ? 255 : m_scnt + ev;
        m_rv = 1; m_wcnt = 0; m_scnt = 0;
      end else begin
        m_wcnt++;
        m_scnt = (m_scnt + ev > 255) ? 255 : m_scnt + ev;
      end
    end
    m_spike_q = sp;
    gcyc++;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    isi_if.isi_ready = 1'b0; isi8_if.isi_ready = 1'b0;
    @(negedge clk);
    apply_reset();

    // Single-cycle spikes at 10, 35, 135 with the consumer always ready.
    for (int t = 0; t < 150; t++) step(t == 10 || t == 35 || t == 135, 1'b1, 1'b1);
    chk_eq("t1_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk_eq("t1_isi0", got_q[0], 25);
      chk_eq("t1_isi1", got_q[1], 100);
    end

    // A spike held high for five cycles is a single event.
    apply_reset();
    for (int t = 0; t < 60; t++) step((t >= 10 && t <= 14) || t == 40, 1'b1, 1'b1);
    chk_eq("t2_count", got_q.size(), 1);
    if (got_q.size() == 1) chk_eq("t2_isi", got_q[0], 30);

    // Consumer stalled: four entries buffer, the fifth ISI is dropped.
    apply_reset();
    for (int t = 0; t < 70; t++) step(t % 10 == 5 && t < 60, 1'b0, 1'b1);
    chk_eq("t3_full", fifo_full, 1);
    chk_eq("t3_overflow", overflow, 1);
    for (int t = 0; t < 10; t++) step(1'b0, 1'b1, 1'b1);
    chk_eq("t3_drain_count", got_q.size(), 4);
    foreach (got_q[i]) chk_eq("t3_drain_val", got_q[i], 10);
    chk_eq("t3_overflow_sticky", overflow, 1);

    // Full FIFO, pop and push on the same edge.
    apply_reset();
    for (int t = 0; t < 55; t++) step(t % 10 == 5, 1'b0, 1'b1);
    chk_eq("t4_full_before", fifo_full, 1);
    step(1'b1, 1'b1, 1'b1);
    for (int t = 0; t < 5; t++) step(1'b0, 1'b0, 1'b1);
    chk_eq("t4_full_after", fifo_full, 1);
    chk_eq("t4_overflow", overflow, 0);
    chk_eq("t4_popped", got_q.size(), 1);
    for (int t = 0; t < 8; t++) step(1'b0, 1'b1, 1'b1);
    chk_eq("t4_drained", got_q.size(), 5);

    // Rate window: spikes every 16 cycles, then a 50-cycle enable gap.
    apply_reset();
    for (int t = 0; t < 1000; t++) step(t % 16 == 0, 1'b1, !(t >= 600 && t < 650));
    chk_eq("t5_pulses", pulses.size(), 3);
    if (pulses.size() == 3) begin
      chk_eq("t5_first_pulse", pulses[0], 256);
      chk_eq("t5_rate", rates[0], 16);
      chk_eq("t5_rate2", rates[1], 16);
      chk_eq("t5_period", pulses[1] - pulses[0], 256);
      chk_eq("t5_period_gap", pulses[2] - pulses[1], 306);
    end

    // ISIs of 300 cycles: 16-bit readout is exact, 8-bit readout saturates.
    apply_reset();
    for (int t = 0; t < 700; t++) step(t == 10 || t == 310 || t == 610, 1'b1, 1'b1);
    chk_eq("t6_count", got8_q.size(), 2);
    foreach (got8_q[i]) chk_eq("t6_sat_w8", got8_q[i], 255);
    foreach (got_q[i]) chk_eq("t6_exact_w16", got_q[i], 300);
    for (int t = 0; t < 40; t++) step(t % 5 == 0 && t > 0, 1'b0, 1'b1);
    chk_eq("t6_pre_rst_overflow", overflow, 1);
    chk_eq("t6_pre_rst_valid", isi_if.isi_valid, 1);
    chk_eq("t6_pre_rst_rate", rate, 1);

    // Mid-stream reset; the first spike afterwards only arms.
    apply_reset();
    for (int t = 0; t < 30; t++) step(t == 10, 1'b1, 1'b1);
    chk_eq("t7_no_entry", got_q.size(), 0);
    chk_eq("t7_armed", dbg_state, 1);
    for (int t = 0; t < 10; t++) step(t == 5, 1'b1, 1'b1);
    chk_eq("t7_first_isi_count", got_q.size(), 1);
    if (got_q.size() == 1) chk_eq("t7_first_isi", got_q[0], 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
